// File: rtl/sync_arith_pkg.sv
// rtl/sync_arith_pkg.sv - shared types and constants for the serial arithmetic cells
package sync_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to count 0..value-1; never less than one.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_sub_bit.sv
// rtl/full_sub_bit.sv - combinational 1-bit full subtractor cell
module full_sub_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/sync_serial_sub.sv
// rtl/sync_serial_sub.sv - bit-serial subtractor, LSB first, one full-subtractor cell
module sync_serial_sub
  import sync_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("sync_serial_sub: WIDTH must be at least 2");
  end

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] res_next;

  full_sub_bit u_cell (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (borrow_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  // Result fills from the top so the LSB lands in bit 0 after WIDTH shifts.
  assign res_next = {cell_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start_valid && start_ready) begin
          a_sh_d   = a;
          b_sh_d   = b;
          res_d    = '0;
          borrow_d = bin;
          cnt_d    = '0;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          state_d  = RUN;
        end
      end
      RUN: begin
        res_d    = res_next;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d  = res_next;
          bout_d  = cell_bout;
          // Signed overflow: operand signs differ and the result sign departs from a.
          ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign start_ready = rst_n && (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign diff        = diff_q;
  assign bout        = bout_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_sync_serial_sub.sv
// tb/tb_sync_serial_sub.sv - randomized self-checking bench for sync_serial_sub
module tb_sync_serial_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         done_valid;
  logic         done_ready;
  logic         busy;

  int vectors;
  int miscompares;

  sync_serial_sub #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .diff        (diff),
    .bout        (bout),
    .ovf         (ovf),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {bout, ovf, diff}.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rbin);
    int ua, ub, sa, sb, s;
    logic [W-1:0] d;
    logic bo, ov;
    ua = int'(ra);
    ub = int'(rb);
    d  = W'(ua - ub - int'(rbin));
    bo = (ua < ub + int'(rbin));
    sa = ra[W-1] ? ua - (1 << W) : ua;
    sb = rb[W-1] ? ub - (1 << W) : ub;
    s  = sa - sb - int'(rbin);
    ov = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    return {bo, ov, d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE; hold keeps done_ready low that many cycles.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                       input int hold);
    logic [W+1:0] exp;
    int lat;
    exp = ref_sub(oa, ob, obin);
    a = oa; b = ob; bin = obin; start_valid = 1'b1;
    vectors++;
    if (start_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL op_start_ready got=%b want=1", start_ready);
    end
    tick;
    start_valid = 1'b0;
    a = $urandom; b = $urandom; bin = $urandom;
    lat = 0;
    while (done_valid !== 1'b1 && lat < W + 6) begin
      tick;
      lat++;
    end
    vectors++;
    if (lat != W) begin
      miscompares++;
      $display("FAIL op_latency got=%0d want=%0d", lat, W);
    end
    for (int h = 0; h <= hold; h++) begin
      vectors++;
      if ({bout, ovf, diff} !== exp || done_valid !== 1'b1 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL op_result a=%h b=%h bin=%b got bout=%b ovf=%b diff=%h dv=%b want bout=%b ovf=%b diff=%h dv=1",
                 oa, ob, obin, bout, ovf, diff, done_valid, exp[W+1], exp[W], exp[W-1:0]);
      end
      if (h < hold) tick;
    end
    done_ready = 1'b1;
    tick;
    done_ready = 1'b0;
    vectors++;
    if (done_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0 ||
        {bout, ovf, diff} !== exp) begin
      miscompares++;
      $display("FAIL op_release got dv=%b sr=%b busy=%b res=%h want dv=0 sr=1 busy=0 res=%h",
               done_valid, start_ready, busy, {bout, ovf, diff}, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    vectors++;
    if ({diff, bout, ovf, done_valid, busy, start_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got diff=%h bout=%b ovf=%b dv=%b busy=%b sr=%b want all 0",
               diff, bout, ovf, done_valid, busy, start_ready);
    end
    rst_n = 1'b1;
    tick;
    vectors++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got sr=%b busy=%b want sr=1 busy=0", start_ready, busy);
    end
  endtask

  task automatic test_directed;
    do_op(8'h05, 8'h03, 1'b0, 0);
    do_op(8'h03, 8'h05, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b1, 0);
    do_op(8'h80, 8'h01, 1'b0, 0);
    do_op(8'h7F, 8'hFF, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 0);
    do_op(8'h80, 8'h00, 1'b1, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) tick;
    end
  endtask

  task automatic test_backpressure;
    logic [W+1:0] exp;
    int lat;
    exp = ref_sub(8'hA5, 8'h3C, 1'b1);
    a = 8'hA5; b = 8'h3C; bin = 1'b1; start_valid = 1'b1;
    tick;
    a = 8'h11; b = 8'h22; bin = 1'b0;
    lat = 0;
    while (done_valid !== 1'b1 && lat < W + 6) begin
      tick;
      lat++;
    end
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if ({bout, ovf, diff} !== exp || done_valid !== 1'b1 || start_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cyc=%0d got res=%h dv=%b sr=%b want res=%h dv=1 sr=0",
                 c, {bout, ovf, diff}, done_valid, start_ready, exp);
      end
      tick;
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    tick;
    done_ready = 1'b0;
    vectors++;
    if (done_valid !== 1'b0 || start_ready !== 1'b1 || {bout, ovf, diff} !== exp) begin
      miscompares++;
      $display("FAIL bp_release got dv=%b sr=%b res=%h want dv=0 sr=1 res=%h",
               done_valid, start_ready, {bout, ovf, diff}, exp);
    end
  endtask

  task automatic test_reset_mid_run;
    logic seen_done;
    a = 8'h9C; b = 8'h21; bin = 1'b0; start_valid = 1'b1;
    tick;
    start_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    vectors++;
    if ({diff, bout, ovf, done_valid, busy, start_ready} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got diff=%h bout=%b ovf=%b dv=%b busy=%b sr=%b want all 0",
               diff, bout, ovf, done_valid, busy, start_ready);
    end
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < W + 3; c++) begin
      tick;
      if (done_valid === 1'b1) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done !== 1'b0 || start_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_no_done got seen_dv=%b sr=%b want seen_dv=0 sr=1",
               seen_done, start_ready);
    end
    do_op(8'h10, 8'h01, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] qa [3];
    logic [W-1:0] qb [3];
    logic         qbin [3];
    int           acc_cyc [3];
    int           n_acc, n_done, cyc;
    logic         accept;
    logic [W+1:0] exp;
    for (int i = 0; i < 3; i++) begin
      qa[i] = W'($urandom); qb[i] = W'($urandom); qbin[i] = 1'($urandom);
      acc_cyc[i] = 0;
    end
    n_acc = 0; n_done = 0; cyc = 0;
    a = qa[0]; b = qb[0]; bin = qbin[0];
    start_valid = 1'b1;
    done_ready = 1'b1;
    while (n_done < 3 && cyc < 200) begin
      accept = start_valid && start_ready;
      if (done_valid === 1'b1) begin
        exp = ref_sub(qa[n_done], qb[n_done], qbin[n_done]);
        vectors++;
        if ({bout, ovf, diff} !== exp) begin
          miscompares++;
          $display("FAIL b2b_result idx=%0d got res=%h want res=%h", n_done, {bout, ovf, diff}, exp);
        end
        n_done++;
      end
      if (accept) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      tick;
      cyc++;
      if (accept) begin
        if (n_acc < 3) begin
          a = qa[n_acc]; b = qb[n_acc]; bin = qbin[n_acc];
        end else begin
          start_valid = 1'b0;
        end
      end
    end
    start_valid = 1'b0;
    done_ready = 1'b0;
    vectors++;
    if (n_done != 3 || n_acc != 3) begin
      miscompares++;
      $display("FAIL b2b_count got done=%0d acc=%0d want 3/3", n_done, n_acc);
    end
    for (int i = 1; i < 3; i++) begin
      vectors++;
      if (acc_cyc[i] - acc_cyc[i-1] != W + 2) begin
        miscompares++;
        $display("FAIL b2b_spacing idx=%0d got=%0d want=%0d", i, acc_cyc[i] - acc_cyc[i-1], W + 2);
      end
    end
    tick;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start_valid = 1'b0;
    done_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid_run;
    test_random;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_serial_sub.md
Name: sync_serial_sub

Overview:
- Synchronous bit-serial subtractor. Computes diff = a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first.
- Uses a single full-subtractor bit cell with a registered borrow loop.
- It is the subtract-direction counterpart to the team's synchronous adder cells. It feeds the ALU datapath where area matters more than latency.
- Operands enter and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- start_valid  in  1  operands a/b/bin valid
- start_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- bin  in  1  borrow-in
- diff  out  WIDTH  result a - b - bin (mod 2^WIDTH)
- bout  out  1  unsigned borrow-out (1 when a < b + bin)
- ovf  out  1  signed two's-complement overflow
- done_valid  out  1  diff/bout/ovf valid
- done_ready  in  1  consumer accepts result
- busy  out  1  high in RUN or DONE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset state (rst_n low at a clk edge): state=IDLE, diff=0, bout=0, ovf=0, done_valid=0, busy=0, bit counter=0, internal shift registers=0. start_ready is forced 0 while rst_n is low.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: load a and b into shift registers, borrow reg <= bin, counter <= 0.
  - Latch a[WIDTH-1] and b[WIDTH-1] for the ovf computation. Go to RUN.
- RUN (one bit per cycle):
  - a0=a_sh[0], b0=b_sh[0], br=borrow reg.
  - d = a0^b0^br.
  - nb = (~a0&b0) | (~(a0^b0)&br).
  - Shift d into the result register MSB (right shift). Shift a_sh and b_sh right. borrow <= nb. counter++.
  - On the cycle processing counter==WIDTH-1: go to DONE. Drive diff from the completed result register, bout <= nb, ovf <= (a_msb!=b_msb) && (d!=a_msb). Set done_valid <= 1.
- Latency: done_valid is high in the cycle after exactly WIDTH rising edges following the accepting edge.
- DONE:
  - done_valid=1. diff/bout/ovf held stable until done_ready.
  - On done_valid&&done_ready: done_valid <= 0, go to IDLE. diff/bout/ovf keep their last values.
- start_ready is 0 in RUN and DONE; start_valid is ignored there. The minimum issue interval is WIDTH+2 cycles (accept, WIDTH bits, handshake out; IDLE re-entered before the next accept).
- done_ready asserted outside DONE has no effect.
- If start_valid is held continuously, the next operand set is accepted on the first IDLE cycle.
- Reset mid-RUN or mid-DONE aborts the operation. All outputs return to reset values and no done_valid pulse is produced.
- Wrap-around: the result is always modulo 2^WIDTH; borrow is reported only via bout.

Decomposition:
- Shared package sync_arith_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH constant
  - counter width function clog2(WIDTH)
- One natural sub-module: full_sub_bit, a combinational 1-bit full subtractor (a, b, bin -> d, bout), instantiated once inside the serial loop. The borrow register stays in the top module.

Test Plan:
- WIDTH=8: a=0x05, b=0x03, bin=0 -> after 8 edges done_valid=1, diff=0x02, bout=0, ovf=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Backpressure: done_ready low for 5 cycles after done_valid -> diff/bout/ovf/done_valid stable, start_ready=0, a new start_valid is ignored. done_ready=1 -> IDLE next cycle.
- Reset mid-operation: rst_n low on the 3rd RUN cycle -> next cycle all outputs are 0, state IDLE, no done_valid. A fresh op 0x10-0x01 then yields diff=0x0F.
- Back-to-back: start_valid and done_ready held high with 3 queued operand sets -> 3 correct results, accepts spaced exactly WIDTH+2 cycles apart.
